// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dand_mem_pkg
// Description : Shared types, address defaults and strobe expansion for the
//               icache/dcache memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dand_mem_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [63:0] C_BASE_ADDR = 64'h8000_0000;
    localparam logic [63:0] C_MEM_BYTES = 64'h8000_0000;

    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] mask;
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Cache command/response, memory and perf-counter bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int IDX_W = 28,
    parameter int CNT_W = 32
);
    logic             icache_cmd_valid;
    logic             icache_cmd_ready;
    logic [63:0]      icache_cmd_payload_addr;
    logic             icache_rsp_valid;
    logic [31:0]      icache_rsp_payload_data;
    logic             icache_rsp_payload_error;

    logic             dcache_cmd_valid;
    logic             dcache_cmd_ready;
    logic [63:0]      dcache_cmd_payload_addr;
    logic             dcache_cmd_payload_wen;
    logic [63:0]      dcache_cmd_payload_wdata;
    logic [7:0]       dcache_cmd_payload_wstrb;
    logic [2:0]       dcache_cmd_payload_size;
    logic             dcache_rsp_valid;
    logic [63:0]      dcache_rsp_payload_data;
    logic             dcache_rsp_payload_error;

    logic             mem_en;
    logic [IDX_W-1:0] mem_idx;
    logic             mem_wen;
    logic [63:0]      mem_wdata;
    logic [63:0]      mem_wmask;
    logic [63:0]      mem_rdata;

    logic [CNT_W-1:0] perf_igrant_cnt;
    logic [CNT_W-1:0] perf_dgrant_cnt;
    logic [CNT_W-1:0] perf_conflict_cnt;

    // Arbiter side
    modport slave (
        input  icache_cmd_valid, icache_cmd_payload_addr,
        output icache_cmd_ready, icache_rsp_valid, icache_rsp_payload_data,
               icache_rsp_payload_error,
        input  dcache_cmd_valid, dcache_cmd_payload_addr, dcache_cmd_payload_wen,
               dcache_cmd_payload_wdata, dcache_cmd_payload_wstrb,
               dcache_cmd_payload_size,
        output dcache_cmd_ready, dcache_rsp_valid, dcache_rsp_payload_data,
               dcache_rsp_payload_error,
        output mem_en, mem_idx, mem_wen, mem_wdata, mem_wmask,
        input  mem_rdata,
        output perf_igrant_cnt, perf_dgrant_cnt, perf_conflict_cnt
    );

    // Core / memory side
    modport master (
        output icache_cmd_valid, icache_cmd_payload_addr,
        input  icache_cmd_ready, icache_rsp_valid, icache_rsp_payload_data,
               icache_rsp_payload_error,
        output dcache_cmd_valid, dcache_cmd_payload_addr, dcache_cmd_payload_wen,
               dcache_cmd_payload_wdata, dcache_cmd_payload_wstrb,
               dcache_cmd_payload_size,
        input  dcache_cmd_ready, dcache_rsp_valid, dcache_rsp_payload_data,
               dcache_rsp_payload_error,
        input  mem_en, mem_idx, mem_wen, mem_wdata, mem_wmask,
        output mem_rdata,
        input  perf_igrant_cnt, perf_dgrant_cnt, perf_conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin arbiter; on conflict the requester not
//               granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dand_mem_pkg::*;
(
    input  wire  clock,
    input  wire  reset_n,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

    owner_e r_last_grant;

    always_comb begin
        gnt_d = req_d && (!req_i || (r_last_grant == OWN_I));
        gnt_i = req_i && !gnt_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= OWN_I;
        end else if (gnt_d) begin
            r_last_grant <= OWN_D;
        end else if (gnt_i) begin
            r_last_grant <= OWN_I;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port doubleword memory between icache and
//               dcache with round-robin grant and 1-cycle responses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import dand_mem_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = C_BASE_ADDR,
    parameter logic [63:0] MEM_BYTES = C_MEM_BYTES,
    parameter int          IDX_W     = 28,
    parameter int          CNT_W     = 32
) (
    input  wire                clock,
    input  wire                reset_n,
    mem_port_arbiter_if.slave  bus
);

    logic        w_gnt_i;
    logic        w_gnt_d;
    logic [63:0] w_i_off;
    logic [63:0] w_d_off;
    logic        w_i_ok;
    logic        w_d_ok;
    logic        w_d_align;
    logic [63:0] w_off;

    owner_e      r_owner;
    logic        r_pend;
    logic        r_err;
    logic        r_hi;

    logic [CNT_W-1:0] r_igrant_cnt;
    logic [CNT_W-1:0] r_dgrant_cnt;
    logic [CNT_W-1:0] r_conflict_cnt;

    // Requests are masked while reset is held so nothing reaches the memory.
    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req_i   (reset_n && bus.icache_cmd_valid),
        .req_d   (reset_n && bus.dcache_cmd_valid),
        .gnt_i   (w_gnt_i),
        .gnt_d   (w_gnt_d)
    );

    assign bus.icache_cmd_ready = w_gnt_i;
    assign bus.dcache_cmd_ready = w_gnt_d;

    // Addresses below base wrap to huge offsets and fail the range test.
    assign w_i_off = bus.icache_cmd_payload_addr - BASE_ADDR;
    assign w_d_off = bus.dcache_cmd_payload_addr - BASE_ADDR;

    always_comb begin
        w_d_align = 1'b0;
        case (bus.dcache_cmd_payload_size)
            3'd0:    w_d_align = 1'b1;
            3'd1:    w_d_align = (bus.dcache_cmd_payload_addr[0]   == 1'b0);
            3'd2:    w_d_align = (bus.dcache_cmd_payload_addr[1:0] == 2'b00);
            3'd3:    w_d_align = (bus.dcache_cmd_payload_addr[2:0] == 3'b000);
            default: w_d_align = 1'b0;
        endcase
    end

    assign w_i_ok = (w_i_off < MEM_BYTES) && (bus.icache_cmd_payload_addr[1:0] == 2'b00);
    assign w_d_ok = (w_d_off < MEM_BYTES) && w_d_align;

    always_comb begin
        w_off         = '0;
        bus.mem_en    = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        if (w_gnt_i) begin
            w_off      = w_i_off;
            bus.mem_en = w_i_ok;
        end else if (w_gnt_d) begin
            w_off      = w_d_off;
            bus.mem_en = w_d_ok;
            if (w_d_ok) begin
                bus.mem_wen   = bus.dcache_cmd_payload_wen;
                bus.mem_wdata = bus.dcache_cmd_payload_wdata;
                bus.mem_wmask = strb_to_mask(bus.dcache_cmd_payload_wstrb);
            end
        end
    end

    assign bus.mem_idx = w_off[IDX_W+2:3];

    logic w_unused_off;
    assign w_unused_off = ^{w_off[63:IDX_W+3], w_off[2:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pend  <= 1'b0;
            r_owner <= OWN_I;
            r_err   <= 1'b0;
            r_hi    <= 1'b0;
        end else begin
            // Clean stores complete silently; faulting stores still report.
            r_pend  <= w_gnt_i || (w_gnt_d && (!bus.dcache_cmd_payload_wen || !w_d_ok));
            r_owner <= w_gnt_d ? OWN_D : OWN_I;
            r_err   <= w_gnt_d ? !w_d_ok : !w_i_ok;
            r_hi    <= w_gnt_d ? bus.dcache_cmd_payload_addr[2] : bus.icache_cmd_payload_addr[2];
        end
    end

    always_comb begin
        bus.icache_rsp_valid         = r_pend && (r_owner == OWN_I);
        bus.icache_rsp_payload_error = bus.icache_rsp_valid && r_err;
        bus.icache_rsp_payload_data  = '0;
        if (bus.icache_rsp_valid && !r_err) begin
            bus.icache_rsp_payload_data = r_hi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
        end
        bus.dcache_rsp_valid         = r_pend && (r_owner == OWN_D);
        bus.dcache_rsp_payload_error = bus.dcache_rsp_valid && r_err;
        bus.dcache_rsp_payload_data  = (bus.dcache_rsp_valid && !r_err) ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_igrant_cnt   <= '0;
            r_dgrant_cnt   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_gnt_i && (r_igrant_cnt != '1)) begin
                r_igrant_cnt <= r_igrant_cnt + CNT_W'(1);
            end
            if (w_gnt_d && (r_dgrant_cnt != '1)) begin
                r_dgrant_cnt <= r_dgrant_cnt + CNT_W'(1);
            end
            if (bus.icache_cmd_valid && bus.dcache_cmd_valid && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.perf_igrant_cnt   = r_igrant_cnt;
    assign bus.perf_dgrant_cnt   = r_dgrant_cnt;
    assign bus.perf_conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench with response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct {
        int          due;
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic clock;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t qi[$];
    exp_t qd[$];
    exp_t ei;
    exp_t ed;

    mem_port_arbiter_if bus ();

    mem_port_arbiter u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Small memory backing the low 16 doublewords; untouched entries read a pattern.
    logic [63:0] ram [16];
    bit   [15:0] touched;

    function automatic logic [63:0] init_word(input int k);
        if (k == 0) return 64'h1111_2222_3333_4444;
        return {32'hCAFE_0000 + 32'(k), 32'hBEEF_0000 + 32'(k)};
    endfunction

    always @(posedge clock) begin
        if (bus.mem_en === 1'b1) begin
            logic [63:0] cur;
            cur = touched[bus.mem_idx[3:0]] ? ram[bus.mem_idx[3:0]] : init_word(int'(bus.mem_idx[3:0]));
            if (bus.mem_wen === 1'b1) begin
                ram[bus.mem_idx[3:0]]     <= (cur & ~bus.mem_wmask) | (bus.mem_wdata & bus.mem_wmask);
                touched[bus.mem_idx[3:0]] <= 1'b1;
            end
            bus.mem_rdata <= cur;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic push_i(input logic [63:0] data, input logic err);
        qi.push_back('{cyc + 1, data, err});
    endtask

    task automatic push_d(input logic [63:0] data, input logic err);
        qd.push_back('{cyc + 1, data, err});
    endtask

    // Response monitor: each expected response must appear exactly on its due cycle.
    always @(negedge clock) begin
        if (qi.size() != 0 && qi[0].due == cyc) begin
            ei = qi.pop_front();
            chk("i_rsp_valid", 64'(bus.icache_rsp_valid), 64'd1);
            chk("i_rsp_data", 64'(bus.icache_rsp_payload_data), ei.data);
            chk("i_rsp_err", 64'(bus.icache_rsp_payload_error), 64'(ei.err));
        end else begin
            chk("i_rsp_idle", 64'(bus.icache_rsp_valid), 64'd0);
        end
        if (qd.size() != 0 && qd[0].due == cyc) begin
            ed = qd.pop_front();
            chk("d_rsp_valid", 64'(bus.dcache_rsp_valid), 64'd1);
            chk("d_rsp_data", bus.dcache_rsp_payload_data, ed.data);
            chk("d_rsp_err", 64'(bus.dcache_rsp_payload_error), 64'(ed.err));
        end else begin
            chk("d_rsp_idle", 64'(bus.dcache_rsp_valid), 64'd0);
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_irdy"}, 64'(bus.icache_cmd_ready), 64'd0);
        chk({tag, "_drdy"}, 64'(bus.dcache_cmd_ready), 64'd0);
        chk({tag, "_idata"}, 64'(bus.icache_rsp_payload_data), 64'd0);
        chk({tag, "_ddata"}, bus.dcache_rsp_payload_data, 64'd0);
        chk({tag, "_ierr"}, 64'(bus.icache_rsp_payload_error), 64'd0);
        chk({tag, "_derr"}, 64'(bus.dcache_rsp_payload_error), 64'd0);
        chk({tag, "_mem_en"}, 64'(bus.mem_en), 64'd0);
        chk({tag, "_mem_wen"}, 64'(bus.mem_wen), 64'd0);
        chk({tag, "_mem_wmask"}, bus.mem_wmask, 64'd0);
        chk({tag, "_icnt"}, 64'(bus.perf_igrant_cnt), 64'd0);
        chk({tag, "_dcnt"}, 64'(bus.perf_dgrant_cnt), 64'd0);
        chk({tag, "_ccnt"}, 64'(bus.perf_conflict_cnt), 64'd0);
    endtask

    initial begin
        reset_n = 1'b1;
        bus.icache_cmd_valid = 1'b0;
        bus.icache_cmd_payload_addr = '0;
        bus.dcache_cmd_valid = 1'b0;
        bus.dcache_cmd_payload_addr = '0;
        bus.dcache_cmd_payload_wen = 1'b0;
        bus.dcache_cmd_payload_wdata = '0;
        bus.dcache_cmd_payload_wstrb = '0;
        bus.dcache_cmd_payload_size = '0;
        #2 reset_n = 1'b0;
        repeat (2) step();
        settle();
        chk_quiet("reset");
        step();
        reset_n = 1'b1;

        // icache fetch, upper word
        step();
        bus.icache_cmd_valid = 1'b1;
        bus.icache_cmd_payload_addr = 64'h8000_0004;
        settle();
        chk("t1_irdy", 64'(bus.icache_cmd_ready), 64'd1);
        chk("t1_drdy", 64'(bus.dcache_cmd_ready), 64'd0);
        chk("t1_mem_en", 64'(bus.mem_en), 64'd1);
        chk("t1_mem_idx", 64'(bus.mem_idx), 64'd0);
        push_i(64'h1111_2222, 1'b0);

        // Conflict: D first, then alternate
        step();
        bus.icache_cmd_payload_addr = 64'h8000_0008;
        bus.dcache_cmd_valid = 1'b1;
        bus.dcache_cmd_payload_addr = 64'h8000_0018;
        bus.dcache_cmd_payload_size = 3'd3;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("cf_drdy", 64'(bus.dcache_cmd_ready), 64'((k % 2) == 0));
            chk("cf_irdy", 64'(bus.icache_cmd_ready), 64'((k % 2) != 0));
            if ((k % 2) == 0) push_d({32'hCAFE_0003, 32'hBEEF_0003}, 1'b0);
            else              push_i(64'hBEEF_0001, 1'b0);
            step();
        end
        bus.icache_cmd_valid = 1'b0;
        bus.dcache_cmd_valid = 1'b0;
        settle();
        chk("cf_ccnt", 64'(bus.perf_conflict_cnt), 64'd4);
        chk("cf_icnt", 64'(bus.perf_igrant_cnt), 64'd3);
        chk("cf_dcnt", 64'(bus.perf_dgrant_cnt), 64'd2);

        // Store low word, then load it back
        step();
        bus.dcache_cmd_valid = 1'b1;
        bus.dcache_cmd_payload_addr = 64'h8000_0010;
        bus.dcache_cmd_payload_wen = 1'b1;
        bus.dcache_cmd_payload_wdata = 64'hAABB_CCDD;
        bus.dcache_cmd_payload_wstrb = 8'h0F;
        bus.dcache_cmd_payload_size = 3'd2;
        settle();
        chk("st_drdy", 64'(bus.dcache_cmd_ready), 64'd1);
        chk("st_mem_en", 64'(bus.mem_en), 64'd1);
        chk("st_mem_wen", 64'(bus.mem_wen), 64'd1);
        chk("st_mem_idx", 64'(bus.mem_idx), 64'd2);
        chk("st_mem_wmask", bus.mem_wmask, 64'h0000_0000_FFFF_FFFF);
        chk("st_mem_wdata", bus.mem_wdata, 64'hAABB_CCDD);
        step();
        bus.dcache_cmd_payload_wen = 1'b0;
        bus.dcache_cmd_payload_size = 3'd3;
        settle();
        chk("ld_mem_wen", 64'(bus.mem_wen), 64'd0);
        chk("ld_mem_idx", 64'(bus.mem_idx), 64'd2);
        push_d({32'hCAFE_0002, 32'hAABB_CCDD}, 1'b0);

        // Faulting dcache accesses
        step();
        bus.dcache_cmd_payload_addr = 64'h7FFF_FFF8;
        settle();
        chk("below_mem_en", 64'(bus.mem_en), 64'd0);
        push_d(64'd0, 1'b1);
        step();
        bus.dcache_cmd_payload_addr = 64'h8000_0002;
        bus.dcache_cmd_payload_size = 3'd2;
        settle();
        chk("mis_mem_en", 64'(bus.mem_en), 64'd0);
        push_d(64'd0, 1'b1);
        step();
        bus.dcache_cmd_payload_addr = 64'h8000_0001;
        bus.dcache_cmd_payload_size = 3'd1;
        bus.dcache_cmd_payload_wen = 1'b1;
        bus.dcache_cmd_payload_wstrb = 8'h03;
        settle();
        chk("fst_mem_wen", 64'(bus.mem_wen), 64'd0);
        chk("fst_mem_wmask", bus.mem_wmask, 64'd0);
        push_d(64'd0, 1'b1);
        step();
        bus.dcache_cmd_payload_addr = 64'h8000_0000;
        bus.dcache_cmd_payload_size = 3'd4;
        bus.dcache_cmd_payload_wen = 1'b0;
        settle();
        chk("sz4_mem_en", 64'(bus.mem_en), 64'd0);
        push_d(64'd0, 1'b1);

        // icache boundaries
        step();
        bus.dcache_cmd_valid = 1'b0;
        bus.icache_cmd_valid = 1'b1;
        bus.icache_cmd_payload_addr = 64'h8000_0002;
        settle();
        chk("imis_mem_en", 64'(bus.mem_en), 64'd0);
        push_i(64'd0, 1'b1);
        step();
        bus.icache_cmd_payload_addr = 64'hFFFF_FFFC;
        settle();
        chk("itop_mem_en", 64'(bus.mem_en), 64'd1);
        chk("itop_mem_idx", 64'(bus.mem_idx), 64'h0FFF_FFFF);
        push_i(64'hCAFE_000F, 1'b0);
        step();
        bus.icache_cmd_payload_addr = 64'h1_0000_0000;
        settle();
        chk("iend_mem_en", 64'(bus.mem_en), 64'd0);
        push_i(64'd0, 1'b1);
        step();
        bus.icache_cmd_valid = 1'b0;

        // Reset between grant and response drops the response
        step();
        bus.icache_cmd_valid = 1'b1;
        bus.icache_cmd_payload_addr = 64'h8000_0004;
        settle();
        chk("rst_irdy", 64'(bus.icache_cmd_ready), 64'd1);
        #1;
        reset_n = 1'b0;
        bus.icache_cmd_valid = 1'b0;
        step();
        settle();
        chk_quiet("midrst");
        step();
        reset_n = 1'b1;
        settle();
        chk("post_icnt", 64'(bus.perf_igrant_cnt), 64'd0);
        step();
        bus.icache_cmd_valid = 1'b1;
        bus.icache_cmd_payload_addr = 64'h8000_0008;
        bus.dcache_cmd_valid = 1'b1;
        bus.dcache_cmd_payload_addr = 64'h8000_0018;
        bus.dcache_cmd_payload_size = 3'd3;
        bus.dcache_cmd_payload_wen = 1'b0;
        settle();
        chk("post_drdy", 64'(bus.dcache_cmd_ready), 64'd1);
        chk("post_irdy", 64'(bus.icache_cmd_ready), 64'd0);
        push_d({32'hCAFE_0003, 32'hBEEF_0003}, 1'b0);
        step();
        settle();
        chk("post2_irdy", 64'(bus.icache_cmd_ready), 64'd1);
        push_i(64'hBEEF_0001, 1'b0);
        step();
        bus.icache_cmd_valid = 1'b0;
        bus.dcache_cmd_valid = 1'b0;

        repeat (3) step();
        settle();
        chk("drain_i", 64'(qi.size()), 64'd0);
        chk("drain_d", 64'(qd.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
